// File: rtl/parity_stream_checker_if.sv
// Valid/ready bus bundle for parity_stream_checker: the upstream beat with its
// per-lane parity code, and the registered downstream beat with its per-lane
// error flags. The master modport is the side that feeds beats in and consumes
// them; the slave modport is the checker itself.
interface parity_stream_checker_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LANE_WIDTH = 8
);
    localparam int LANES = DATA_WIDTH / LANE_WIDTH;

    logic [DATA_WIDTH-1:0] upstream_data;
    logic [LANES-1:0]      upstream_code;
    logic                  upstream_valid;
    logic                  upstream_ready;
    logic [DATA_WIDTH-1:0] downstream_data;
    logic [LANES-1:0]      downstream_error;
    logic                  downstream_valid;
    logic                  downstream_ready;

    modport master (
        output upstream_data,
        output upstream_code,
        output upstream_valid,
        output downstream_ready,
        input  upstream_ready,
        input  downstream_data,
        input  downstream_error,
        input  downstream_valid
    );

    modport slave (
        input  upstream_data,
        input  upstream_code,
        input  upstream_valid,
        input  downstream_ready,
        output upstream_ready,
        output downstream_data,
        output downstream_error,
        output downstream_valid
    );
endinterface

// File: rtl/parity_stream_checker.sv
// parity_stream_checker: single-stage registered even-parity checker for a
// multi-lane valid/ready stream. Each lane's data XORed with its code bit must
// be 0; failing lanes are flagged alongside the registered beat, and sticky
// per-lane status accumulates over accepted beats until cleared.
// Optional feature macro: PARITY_STREAM_CHECKER_COUNTER_EN adds the error_count
// port with a saturating errored-beat counter.
module parity_stream_checker #(
    parameter int  DATA_WIDTH    = 32,
    parameter int  LANE_WIDTH    = 8,
    parameter int  COUNTER_WIDTH = 8,
    localparam int LANES         = DATA_WIDTH / LANE_WIDTH
) (
    input  logic                     clock,
    input  logic                     resetn,
    parity_stream_checker_if.slave   bus,
    input  logic                     clear,
    output logic                     error_sticky,
    output logic [LANES-1:0]         error_lanes_sticky
`ifdef PARITY_STREAM_CHECKER_COUNTER_EN
    ,
    output logic [COUNTER_WIDTH-1:0] error_count
`endif
);

    // Elaboration-time guard on the geometry and counter width.
    if ((DATA_WIDTH % LANE_WIDTH) != 0 || COUNTER_WIDTH < 1) begin : g_bad_params
        $error("parity_stream_checker: LANE_WIDTH must divide DATA_WIDTH and COUNTER_WIDTH must be >= 1");
    end

    // Per-lane even-parity check: a set bit marks a lane whose data XOR code is 1.
    function automatic logic [LANES-1:0] lane_errors(
        input logic [DATA_WIDTH-1:0] data,
        input logic [LANES-1:0]      code
    );
        logic [LANES-1:0] err;
        err = {LANES{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            err[i] = (^data[i*LANE_WIDTH +: LANE_WIDTH]) ^ code[i];
        end
        return err;
    endfunction

    logic [DATA_WIDTH-1:0] data_r;
    logic [LANES-1:0]      error_r;
    logic                  valid_r;
    logic [LANES-1:0]      lanes_sticky_r;
    logic                  sticky_r;

    logic                  ready_s;
    logic                  accept_s;
    logic [LANES-1:0]      check_s;
    logic                  errored_s;
    logic [LANES-1:0]      lanes_base_s;
    logic [LANES-1:0]      lanes_next_s;

    assign ready_s   = !valid_r || bus.downstream_ready;
    assign accept_s  = bus.upstream_valid && ready_s;
    assign check_s   = lane_errors(bus.upstream_data, bus.upstream_code);
    assign errored_s = |check_s;

    // Next sticky lane status: clear drops history, a concurrent accept still ORs its vector in.
    always_comb begin
        lanes_base_s = lanes_sticky_r;
        lanes_next_s = lanes_sticky_r;
        if (clear) begin
            lanes_base_s = {LANES{1'b0}};
        end else begin
            lanes_base_s = lanes_sticky_r;
        end
        if (accept_s) begin
            lanes_next_s = lanes_base_s | check_s;
        end else begin
            lanes_next_s = lanes_base_s;
        end
    end

    // Output stage: load on accept, drop valid on a transfer with no refill, otherwise hold.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            data_r  <= {DATA_WIDTH{1'b0}};
            error_r <= {LANES{1'b0}};
            valid_r <= 1'b0;
        end else if (accept_s) begin
            data_r  <= bus.upstream_data;
            error_r <= check_s;
            valid_r <= 1'b1;
        end else if (bus.downstream_ready) begin
            valid_r <= 1'b0;
        end
    end

    // Sticky status registers, updated on accept so they move together with downstream_valid.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lanes_sticky_r <= {LANES{1'b0}};
            sticky_r       <= 1'b0;
        end else begin
            lanes_sticky_r <= lanes_next_s;
            sticky_r       <= |lanes_next_s;
        end
    end

`ifdef PARITY_STREAM_CHECKER_COUNTER_EN
    logic [COUNTER_WIDTH-1:0] count_r;

    // Saturating errored-beat counter; an errored accept during clear restarts it at one.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_r <= {COUNTER_WIDTH{1'b0}};
        end else if (accept_s && errored_s) begin
            if (clear) begin
                count_r <= COUNTER_WIDTH'(1);
            end else if (count_r != {COUNTER_WIDTH{1'b1}}) begin
                count_r <= count_r + COUNTER_WIDTH'(1);
            end
        end else if (clear) begin
            count_r <= {COUNTER_WIDTH{1'b0}};
        end
    end

    assign error_count = count_r;
`endif

    assign bus.upstream_ready   = ready_s;
    assign bus.downstream_data  = data_r;
    assign bus.downstream_error = error_r;
    assign bus.downstream_valid = valid_r;
    assign error_sticky         = sticky_r;
    assign error_lanes_sticky   = lanes_sticky_r;

endmodule

// File: tb/tb_parity_stream_checker.sv
// Scoreboard bench for parity_stream_checker: the driver pushes the expected
// beat (data, error vector, status snapshot) when a beat is accepted, and a
// negedge monitor compares whatever the DUT presents against the queue head.
module tb_parity_stream_checker;
    localparam int DW   = 32;
    localparam int LW   = 8;
    localparam int NL   = DW / LW;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic [DW-1:0] data;
        logic [NL-1:0] err;
        logic [NL-1:0] lanes;
        logic          sticky;
        int            count;
    } exp_t;

    logic          clock;
    logic          resetn;
    logic          clear;
    logic          error_sticky;
    logic [NL-1:0] error_lanes_sticky;
    logic [CW-1:0] error_count;

    parity_stream_checker_if #(.DATA_WIDTH(DW), .LANE_WIDTH(LW)) bus ();

    parity_stream_checker #(
        .DATA_WIDTH(DW), .LANE_WIDTH(LW), .COUNTER_WIDTH(CW)
    ) dut (
        .clock              (clock),
        .resetn             (resetn),
        .bus                (bus),
        .clear              (clear),
        .error_sticky       (error_sticky),
        .error_lanes_sticky (error_lanes_sticky)
`ifdef PARITY_STREAM_CHECKER_COUNTER_EN
        ,
        .error_count        (error_count)
`endif
    );

`ifndef PARITY_STREAM_CHECKER_COUNTER_EN
    assign error_count = '0;
`endif

    int   tests     = 0;
    int   fails     = 0;
    int   transfers = 0;
    exp_t q[$];

    // model state for sticky status
    logic [NL-1:0] m_lanes;
    int            m_count;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lanes = '0;
        m_count = 0;
        q.delete();
    endtask

    // Expected status after accepting a beat with error vector e (clr = concurrent clear).
    task automatic model_accept(input logic [DW-1:0] d, input logic [NL-1:0] e, input bit clr);
        exp_t x;
        if (clr) m_lanes = '0;
        m_lanes = m_lanes | e;
        if (e != '0) m_count = clr ? 1 : ((m_count == CMAX) ? CMAX : m_count + 1);
        else if (clr) m_count = 0;
        x.data = d; x.err = e; x.lanes = m_lanes; x.sticky = |m_lanes; x.count = m_count;
        q.push_back(x);
    endtask

    // Drive one beat from posedge+1, wait (bounded) for acceptance, return wait cycles.
    task automatic send(input logic [DW-1:0] d, input logic [NL-1:0] c, input logic [NL-1:0] e,
                        input bit clr, output int waits);
        bus.upstream_data  = d;
        bus.upstream_code  = c;
        bus.upstream_valid = 1'b1;
        clear              = clr;
        waits = 0;
        @(negedge clock);
        while (!bus.upstream_ready && waits < 50) begin
            waits++;
            @(negedge clock);
        end
        if (!bus.upstream_ready) begin
            check("accept_timeout", 64'(0), 64'(1));
        end else begin
            model_accept(d, e, clr);
        end
        @(posedge clock);
        #1;
        bus.upstream_valid = 1'b0;
        clear              = 1'b0;
    endtask

    // Monitor: compare the presented beat with the queue head; pop on transfer.
    always @(negedge clock) begin
        if (resetn && bus.downstream_valid) begin
            if (q.size() == 0) begin
                check("unexpected_beat", 64'(bus.downstream_data), 64'(0));
            end else begin
                check("ds_data",   64'(bus.downstream_data),  64'(q[0].data));
                check("ds_error",  64'(bus.downstream_error), 64'(q[0].err));
                check("lanes_sticky", 64'(error_lanes_sticky), 64'(q[0].lanes));
                check("error_sticky", 64'(error_sticky),      64'(q[0].sticky));
`ifdef PARITY_STREAM_CHECKER_COUNTER_EN
                check("error_count", 64'(error_count), 64'(q[0].count));
`endif
                if (bus.downstream_ready) begin
                    void'(q.pop_front());
                    transfers++;
                end
            end
        end
    end

    logic [DW-1:0] vd[8] = '{32'h00000000, 32'hFFFFFFFF, 32'h80000001, 32'h00FF7F00,
                             32'h00FF7F00, 32'h12345678, 32'h12345678, 32'hA5A5A5A5};
    logic [NL-1:0] vc[8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
                             4'b0010, 4'b0100, 4'b1111, 4'b0101};
    logic [NL-1:0] ve[8] = '{4'b0000, 4'b0000, 4'b1001, 4'b0010,
                             4'b0000, 4'b0000, 4'b1011, 4'b0101};

    initial begin
        int w;
        int t0;
        resetn = 1'b0;
        clear  = 1'b0;
        bus.upstream_data    = '0;
        bus.upstream_code    = '0;
        bus.upstream_valid   = 1'b0;
        bus.downstream_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid",  64'(bus.downstream_valid), 64'(0));
        check("rst_data",   64'(bus.downstream_data),  64'(0));
        check("rst_error",  64'(bus.downstream_error), 64'(0));
        check("rst_sticky", 64'(error_sticky),         64'(0));
        check("rst_lanes",  64'(error_lanes_sticky),   64'(0));
        check("rst_count",  64'(error_count),          64'(0));
        check("rst_ready",  64'(bus.upstream_ready),   64'(1));
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // basic good then bad beat
        send(32'h01020304, 4'b1101, 4'b0000, 1'b0, w);
        send(32'h01020304, 4'b1111, 4'b0010, 1'b0, w);
        @(posedge clock);
        #1;
        check("basic_lanes",  64'(error_lanes_sticky), 64'(4'b0010));
        check("basic_sticky", 64'(error_sticky),       64'(1));
`ifdef PARITY_STREAM_CHECKER_COUNTER_EN
        check("basic_count",  64'(error_count),        64'(1));
`endif

        // back-to-back burst with downstream_ready held high
        t0 = transfers;
        for (int i = 0; i < 8; i++) begin
            send(vd[i], vc[i], ve[i], 1'b0, w);
            check("burst_no_stall", 64'(w), 64'(0));
        end
        repeat (2) @(posedge clock);
        #1;
        check("burst_transfers", 64'(transfers - t0), 64'(10 - 2));

        // backpressure: hold beat A, offer B, then release
        bus.downstream_ready = 1'b0;
        send(32'h0000_00FF, 4'b0001, 4'b0001, 1'b0, w);
        bus.upstream_data  = 32'h0000_0001;
        bus.upstream_code  = 4'b0001;
        bus.upstream_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("hold_ready_low", 64'(bus.upstream_ready), 64'(0));
            check("hold_data", 64'(bus.downstream_data), 64'(32'h0000_00FF));
        end
        @(posedge clock);
        #1;
        bus.downstream_ready = 1'b1;
        #1;
        check("release_ready", 64'(bus.upstream_ready), 64'(1));
        model_accept(32'h0000_0001, 4'b0000, 1'b0);
        @(posedge clock);
        #1;
        bus.upstream_valid = 1'b0;
        check("same_cycle_refill", 64'(bus.downstream_data), 64'(32'h0000_0001));
        repeat (2) @(posedge clock);
        #1;

        // standalone clear with an empty stage
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        m_lanes = '0;
        m_count = 0;
        check("clear_lanes",  64'(error_lanes_sticky), 64'(0));
        check("clear_sticky", 64'(error_sticky),       64'(0));
        check("clear_count",  64'(error_count),        64'(0));

        // five errored beats saturate the 2-bit counter, then clear + errored beat
        for (int i = 0; i < 5; i++) send(32'h12345678, 4'b0000, 4'b0100, 1'b0, w);
        @(posedge clock);
        #1;
`ifdef PARITY_STREAM_CHECKER_COUNTER_EN
        check("count_saturated", 64'(error_count), 64'(3));
`endif
        send(32'h80000001, 4'b0000, 4'b1001, 1'b1, w);
        @(posedge clock);
        #1;
        check("clear_set_lanes", 64'(error_lanes_sticky), 64'(4'b1001));
`ifdef PARITY_STREAM_CHECKER_COUNTER_EN
        check("clear_set_count", 64'(error_count), 64'(1));
`endif

        // reset asserted while a beat is held
        bus.downstream_ready = 1'b0;
        send(32'hDEADBEEF, 4'b0000, 4'b0000, 1'b0, w);
        check("pre_reset_valid", 64'(bus.downstream_valid), 64'(1));
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check("mid_rst_valid",  64'(bus.downstream_valid), 64'(0));
        check("mid_rst_data",   64'(bus.downstream_data),  64'(0));
        check("mid_rst_lanes",  64'(error_lanes_sticky),   64'(0));
        check("mid_rst_sticky", 64'(error_sticky),         64'(0));
        check("mid_rst_count",  64'(error_count),          64'(0));
        @(negedge clock);
        resetn = 1'b1;
        bus.downstream_ready = 1'b1;
        @(posedge clock);
        #1;
        check("post_rst_ready", 64'(bus.upstream_ready), 64'(1));
        send(32'h01020304, 4'b1111, 4'b0010, 1'b0, w);
        repeat (2) @(posedge clock);
        #1;
        check("queue_drained", 64'(q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/parity_stream_checker.md
# parity_stream_checker

Pipelined, multi-lane parity checker for a valid/ready data stream. Each beat is split into independent lanes; every lane carries one even-parity code bit (XOR of the lane's data bits). The block registers the beat with per-lane error flags, keeps sticky error status, and optionally counts errored beats. It sits at the receive side of any parity-protected link or storage read-back path, after a per-lane parity encoder on the transmit side.

## Interface
- DATA_WIDTH, 32, total data bits per beat.
- LANE_WIDTH, 8, data bits per parity lane; must divide DATA_WIDTH exactly. LANES = DATA_WIDTH/LANE_WIDTH is derived, not a parameter.
- COUNTER_WIDTH, 8, width of the errored-beat counter.

- clock  input  1  single clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- upstream_data  input  DATA_WIDTH  beat data; lane i = bits [i*LANE_WIDTH +: LANE_WIDTH].
- upstream_code  input  LANES  parity bit i protects lane i.
- upstream_valid  input  1  beat present.
- upstream_ready  output  1  block accepts the beat this cycle.
- downstream_data  output  DATA_WIDTH  registered beat data, unmodified.
- downstream_error  output  LANES  bit i set if lane i failed its check.
- downstream_valid  output  1  registered beat present.
- downstream_ready  input  1  consumer accepts the beat.
- clear  input  1  synchronous clear of sticky status and counter.
- error_sticky  output  1  set once any errored beat has been accepted.
- error_lanes_sticky  output  LANES  OR of all downstream_error values accepted since the last clear.
- error_count  output  COUNTER_WIDTH  errored-beat count (present only with counter macro).

## Operation
- Check: lane i errors when XOR(lane i data) XOR upstream_code[i] = 1. Even parity; all-zero data with code 0 is valid.
- Single pipeline stage. upstream_ready = !downstream_valid || downstream_ready, combinational; no bubble at full throughput.
- Accept (upstream_valid && upstream_ready): load data and computed error vector into the output register; set downstream_valid.
- downstream_ready && downstream_valid with no new accept: clear downstream_valid. Data/error registers hold their last value.
- Output stage holds beat stable while downstream_valid && !downstream_ready.
- Status updates on accept, not on downstream transfer. An errored beat is one with any error bit set.
- error_lanes_sticky |= new error vector; error_sticky = |error_lanes_sticky.
- clear and an errored accept in the same cycle: status reflects only the new beat (set wins over clear).
- Counter (when compiled in): +1 per errored beat accepted, saturates at 2^COUNTER_WIDTH-1; clear sets 0, or 1 if an errored beat is accepted the same cycle.

## Timing
- Latency: 1 cycle from accept to downstream_valid.
- Reset values: downstream_valid 0, downstream_data 0, downstream_error 0, error_sticky 0, error_lanes_sticky 0, error_count 0; upstream_ready 1 while in reset-exit state.
- Reset asserted mid-transfer: the held beat is discarded; no status retained.
- Status outputs change the cycle after the accepting edge, together with downstream_valid.

## Configuration
- PARITY_STREAM_CHECKER_COUNTER_EN: defined, error_count port and saturating counter exist as described. Undefined, the port and counter are absent; all other behaviour identical.

## Test plan
- DATA_WIDTH 32, LANE_WIDTH 8: send 0x01020304 with code 4'b1101 -> next cycle downstream_valid 1, downstream_error 4'b0000, error_sticky 0.
- Same data, code 4'b1111 -> downstream_error 4'b0010, error_lanes_sticky 4'b0010, error_sticky 1, error_count 1.
- Back-to-back 8 beats with downstream_ready held 1 -> upstream_ready stays 1, one beat out per cycle, order preserved.
- Hold downstream_ready 0 with beat stored -> upstream_ready 0, outputs stable; raise downstream_ready -> beat transferred and next beat accepted in the same cycle.
- COUNTER_WIDTH 2, send 5 errored beats -> error_count 3 (saturated); pulse clear concurrently with a 6th errored beat -> error_count 1, error_lanes_sticky = that beat's vector.
- Assert resetn low while downstream_valid 1 -> all outputs 0 immediately, upstream_ready 1 after release.
